rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Two-port arbiter that shares the single-read-port instruction/data ROM between the instruction-fetch (IF) and load/store (LS) requesters. Each port has a valid/ready request channel and a response channel. The arbiter grants at most one request per cycle, drives the ROM request interface, and routes the one-cycle-later ROM data back to the port that issued it. It sits between the core's fetch/LSU front ends and the ROM.

## Interface
- `ADDR_W`, default 32: request address width.
- `ROM_WORDS_LOG2`, default 14: ROM depth in words. Addresses at or above `4 << ROM_WORDS_LOG2` are out of range.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `if_req_valid` input 1: IF request present.
- `if_req_ready` output 1: IF request accepted this cycle.
- `if_req_addr` input ADDR_W: IF byte address.
- `if_resp_valid` output 1: IF response valid, one-cycle pulse.
- `if_resp_data` output 32: IF read data.
- `if_resp_err` output 1: IF misaligned or out-of-range access.
- `ls_req_valid`, `ls_req_ready`, `ls_req_addr`, `ls_resp_valid`, `ls_resp_data`, `ls_resp_err`: same as the IF signals, for the LS port.
- `rom_rx_valid` output 1: ROM read strobe.
- `rom_rx_addr` output 32: ROM byte address.
- `rom_tx_valid` input 1: ROM valid. Sticky high after the first read, so the arbiter ignores it.
- `rom_tx_data` input 32: ROM data, valid the cycle after the strobe.

## Operation
- A request is accepted when `x_req_valid && x_req_ready`.
- `x_req_ready` is combinational and equals the grant. Ready may depend on valid. Valid must not depend on ready.
- Arbitration happens only between ports with valid high. A lone requester is always granted in the same cycle.
- Error check on the granted address: `addr[1:0] != 0` or out of range.
  - Error: no ROM strobe is issued. The response has err=1 and data=0.
  - No error: `rom_rx_valid=1` and `rom_rx_addr=addr` in the grant cycle.
- FSM states:
  - IDLE → BUSY on any grant.
  - BUSY → BUSY on a new grant in the same cycle (back-to-back).
  - BUSY → IDLE when there is no grant.
  - BUSY means one response is due this cycle.
- Registered in-flight tag captures the granted port and the err flag at the grant edge.
- Responses carry no backpressure. Requesters must sink the response in the cycle it appears.
- `x_resp_data` = `rom_tx_data` when the tag selects that port and err=0. Otherwise it is 0.
- The non-selected port's resp_valid, data and err are all 0.

## Timing
- Reset values (sync, next edge):
  - FSM = IDLE, tag cleared, priority pointer = IF.
  - All `*_resp_valid`, `*_resp_err` = 0 and `*_resp_data` = 0.
  - `rom_rx_valid` = 0 whenever no request is pending.
- Latency: accept at cycle N → response at N+1. Throughput is 1 grant/cycle total.
- Simultaneous valid on both ports: exactly one ready. The loser keeps valid and addr stable and is granted on a later cycle.
- Reset asserted while BUSY: the pending response is dropped and no resp_valid appears after reset.
- Grants in the reset cycle are suppressed (both ready=0).

## Configuration
- `ROM_ARB_RR_EN` defined:
  - Round-robin arbitration. The pointer flips to the other port after every grant.
  - Under continuous contention the ports alternate IF, LS, IF, …
- Undefined:
  - Fixed priority, LS over IF, with no pointer register.
  - IF starves while LS is continuously valid.

## Structure
- Package `rom_arb_pkg` holds:
  - `port_e` {PORT_IF=0, PORT_LS=1}.
  - `state_e` {IDLE, BUSY}.
  - A tag struct {port, err}.
  - The alignment/range check function.
- Sub-module `rom_arb_grant2`: 2-way grant logic. Takes the request vector and pointer; outputs a one-hot grant. The fixed/RR choice lives here under the macro.

## Test plan
- IF only: addr 0x10 → `rom_rx_valid` with addr 0x10 in the same cycle; next cycle `if_resp_valid=1`, data = mem[4], err=0, LS outputs 0.
- Both valid continuously for 4 cycles:
  - RR: grants IF, LS, IF, LS.
  - Fixed: LS ×4 and `if_req_ready` stays 0.
  - Each response is on the correct port one cycle later.
- Misaligned LS addr 0x6 → `ls_req_ready=1`, no `rom_rx_valid`; next cycle `ls_resp_err=1`, data=0.
- Out of range: IF addr 0x10000 (default params) → err=1, no ROM strobe.
- Back-to-back IF 0x0, 0x4, 0x8 → three consecutive responses mem[0..2]. The FSM stays BUSY, then returns to IDLE.
- `rst` pulsed the cycle after an accept → no resp_valid in any later cycle. Outputs are 0 and the pointer returns to IF.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and the address check for the two-port ROM arbiter.
package rom_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ROM_ADDR_W = 32;
  // Width used for the range compare; wide enough for any practical ADDR_W.
  localparam int unsigned CHK_W      = 64;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // In-flight response tag captured at the grant edge.
  typedef struct packed {
    port_e port;
    logic  err;
  } tag_t;

  localparam tag_t TAG_RESET = '{port: PORT_IF, err: 1'b0};

  // Misaligned (not word aligned) or beyond the last ROM byte.
  function automatic logic addr_err(input logic [CHK_W-1:0] addr,
                                    input int unsigned      words_log2);
    logic [CHK_W-1:0] limit;
    limit = CHK_W'(4) << words_log2;
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

  function automatic port_e other_port(input port_e p);
    return (p == PORT_IF) ? PORT_LS : PORT_IF;
  endfunction

endpackage

// File: rtl/rom_arb_grant2.sv
// rom_arb_grant2: two-way one-hot grant (bit 0 = IF, bit 1 = LS).
// ROM_ARB_RR_EN selects round-robin on ptr; otherwise LS has fixed priority.
import rom_arb_pkg::*;

module rom_arb_grant2 (
  input  logic [1:0] req,
  input  port_e      ptr,
  output logic [1:0] gnt
);

`ifdef ROM_ARB_RR_EN
  // Contention resolved towards the port the pointer favours.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (ptr == PORT_IF) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  // LS always wins when present; IF only when LS is idle.
  always_comb begin
    gnt = 2'b00;
    if (req[1]) begin
      gnt = 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single-read-port ROM between IF and LS requesters.
// One grant per cycle, response one cycle later on the granting port.
// Macro ROM_ARB_RR_EN: round-robin arbitration (default: fixed LS priority).
import rom_arb_pkg::*;

module rom_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned ROM_WORDS_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_resp_data,
  output logic                  if_resp_err,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_req_addr,
  output logic                  ls_resp_valid,
  output logic [DATA_W-1:0]     ls_resp_data,
  output logic                  ls_resp_err,

  output logic                  rom_rx_valid,
  output logic [ROM_ADDR_W-1:0] rom_rx_addr,
  input  logic                  rom_tx_valid,
  input  logic [DATA_W-1:0]     rom_tx_data
);

  state_e state_q, state_d;
  tag_t   tag_q, tag_d;
  port_e  ptr;

  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              any_gnt;
  port_e             gnt_port;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_err;

  // ROM valid is sticky after the first read and carries no information.
  logic unused_rom_tx_valid;
  assign unused_rom_tx_valid = rom_tx_valid;

`ifdef ROM_ARB_RR_EN
  port_e ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = PORT_IF;
`endif

  // Requests are masked during reset so nothing is granted in that cycle.
  always_comb begin
    req_vec = {ls_req_valid, if_req_valid} & {2{~rst}};
  end

  rom_arb_grant2 u_grant (
    .req (req_vec),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Select the granted request and check its address.
  always_comb begin
    any_gnt  = |gnt;
    gnt_port = gnt[1] ? PORT_LS : PORT_IF;
    gnt_addr = gnt[1] ? ls_req_addr : if_req_addr;
    gnt_err  = any_gnt && addr_err(CHK_W'(gnt_addr), ROM_WORDS_LOG2);
  end

  // Ready is the grant; the ROM is strobed only for clean addresses.
  always_comb begin
    if_req_ready = gnt[0];
    ls_req_ready = gnt[1];
    rom_rx_valid = any_gnt && !gnt_err;
    rom_rx_addr  = rom_rx_valid ? ROM_ADDR_W'(gnt_addr) : '0;
  end

  // State register: FSM, in-flight tag and (round-robin only) pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= TAG_RESET;
`ifdef ROM_ARB_RR_EN
      ptr_q   <= PORT_IF;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
`ifdef ROM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next state: BUSY for exactly the cycles following a grant.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
`ifdef ROM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE:    state_d = any_gnt ? BUSY : IDLE;
      BUSY:    state_d = any_gnt ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (any_gnt) begin
      tag_d = '{port: gnt_port, err: gnt_err};
`ifdef ROM_ARB_RR_EN
      ptr_d = other_port(gnt_port);
`endif
    end
  end

  // Outputs: route the due response to the tagged port, zero elsewhere.
  always_comb begin
    if_resp_valid = 1'b0;
    if_resp_err   = 1'b0;
    if_resp_data  = '0;
    ls_resp_valid = 1'b0;
    ls_resp_err   = 1'b0;
    ls_resp_data  = '0;
    if ((state_q == BUSY) && !rst) begin
      if (tag_q.port == PORT_IF) begin
        if_resp_valid = 1'b1;
        if_resp_err   = tag_q.err;
        if_resp_data  = tag_q.err ? '0 : rom_tx_data;
      end else begin
        ls_resp_valid = 1'b1;
        ls_resp_err   = tag_q.err;
        ls_resp_data  = tag_q.err ? '0 : rom_tx_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and randomized checks of rom_arbiter against a
// transaction-level model (grant choice, error rule, one-cycle response).
module tb_rom_arbiter;

`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0, ls_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0, ls_req_addr = '0;
  logic        if_req_ready, ls_req_ready;
  logic        if_resp_valid, ls_resp_valid, if_resp_err, ls_resp_err;
  logic [31:0] if_resp_data, ls_resp_data;
  logic        rom_rx_valid;
  logic [31:0] rom_rx_addr;
  logic        rom_tx_valid = 1'b0;
  logic [31:0] rom_tx_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(32), .ROM_WORDS_LOG2(14)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
    .rom_rx_valid(rom_rx_valid), .rom_rx_addr(rom_rx_addr),
    .rom_tx_valid(rom_tx_valid), .rom_tx_data(rom_tx_data)
  );

  // ROM contents: a fixed scramble of the word index.
  function automatic logic [31:0] memf(input logic [29:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ROM model: data one cycle after the strobe, junk when not strobed.
  always @(posedge clk) begin
    if (rom_rx_valid) begin
      rom_tx_data  <= memf(rom_rx_addr[31:2]);
      rom_tx_valid <= 1'b1;
    end else begin
      rom_tx_data  <= 32'hDEAD_BEEF;
    end
  end

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0001_0000);
  endfunction

  function automatic logic [31:0] gen_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 16383)) * 4;
    if (r == 7) return 32'($urandom_range(0, 16383)) * 4 + 32'($urandom_range(1, 3));
    return 32'h0001_0000 + 32'($urandom_range(0, 4095)) * 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la);
    if_req_valid = iv;
    if_req_addr  = ia;
    ls_req_valid = lv;
    ls_req_addr  = la;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 32'h20);
    #1;
    total++; if ({if_req_ready, ls_req_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {if_req_ready, ls_req_ready}); end
    total++; if (rom_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rom_strobe got=%b exp=0", rom_rx_valid); end
    tick();
    total++; if ({if_resp_valid, ls_resp_valid, if_resp_err, ls_resp_err} !== 4'b0000) begin bad++; $display("FAIL reset_resp_flags got=%b exp=0000", {if_resp_valid, ls_resp_valid, if_resp_err, ls_resp_err}); end
    total++; if ({if_resp_data, ls_resp_data} !== 64'd0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", {if_resp_data, ls_resp_data}); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    tick();
  endtask

  task automatic test_if_only();
    reset_dut();
    drive(1'b1, 32'h10, 1'b0, '0);
    #1;
    total++; if ({if_req_ready, ls_req_ready} !== 2'b10) begin bad++; $display("FAIL if_only_ready got=%b exp=10", {if_req_ready, ls_req_ready}); end
    total++; if ({rom_rx_valid, rom_rx_addr} !== {1'b1, 32'h10}) begin bad++; $display("FAIL if_only_strobe got=%b/%h exp=1/00000010", rom_rx_valid, rom_rx_addr); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    #1;
    total++; if ({if_resp_valid, if_resp_err, if_resp_data} !== {2'b10, memf(30'd4)}) begin bad++; $display("FAIL if_only_resp got=%b/%b/%h exp=1/0/%h", if_resp_valid, if_resp_err, if_resp_data, memf(30'd4)); end
    total++; if ({ls_resp_valid, ls_resp_err, ls_resp_data} !== 34'd0) begin bad++; $display("FAIL if_only_ls_quiet got=%b/%b/%h exp=0/0/0", ls_resp_valid, ls_resp_err, ls_resp_data); end
    tick();
    total++; if (if_resp_valid !== 1'b0) begin bad++; $display("FAIL if_only_idle got=%b exp=0", if_resp_valid); end
  endtask

  task automatic test_contention();
    logic exp_ls, prev_ls;
    prev_ls = 1'b0;
    reset_dut();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b1, 32'h20, 1'b1, 32'h40);
      else drive(1'b0, '0, 1'b0, '0);
      #1;
      if (i < 4) begin
        exp_ls = RR ? (i % 2 == 1) : 1'b1;
        total++; if ({if_req_ready, ls_req_ready} !== {~exp_ls, exp_ls}) begin bad++; $display("FAIL contend_grant[%0d] got if=%b ls=%b exp if=%b ls=%b", i, if_req_ready, ls_req_ready, ~exp_ls, exp_ls); end
      end else begin
        exp_ls = 1'b0;
      end
      if (i > 0) begin
        total++;
        if ({if_resp_valid, ls_resp_valid} !== {~prev_ls, prev_ls} ||
            (prev_ls ? ls_resp_data : if_resp_data) !== (prev_ls ? memf(30'd16) : memf(30'd8))) begin
          bad++; $display("FAIL contend_resp[%0d] got v=%b%b ifd=%h lsd=%h exp ls_port=%b", i, if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data, prev_ls);
        end
      end
      prev_ls = exp_ls;
      tick();
    end
  endtask

  task automatic test_misaligned_ls();
    reset_dut();
    drive(1'b0, '0, 1'b1, 32'h6);
    #1;
    total++; if ({ls_req_ready, rom_rx_valid} !== 2'b10) begin bad++; $display("FAIL misalign_grant got ready=%b strobe=%b exp ready=1 strobe=0", ls_req_ready, rom_rx_valid); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    #1;
    total++; if ({ls_resp_valid, ls_resp_err, ls_resp_data} !== {2'b11, 32'd0}) begin bad++; $display("FAIL misalign_resp got=%b/%b/%h exp=1/1/0", ls_resp_valid, ls_resp_err, ls_resp_data); end
    total++; if (if_resp_valid !== 1'b0) begin bad++; $display("FAIL misalign_if_quiet got=%b exp=0", if_resp_valid); end
    tick();
  endtask

  task automatic test_out_of_range();
    reset_dut();
    drive(1'b1, 32'h0001_0000, 1'b0, '0);
    #1;
    total++; if ({if_req_ready, rom_rx_valid} !== 2'b10) begin bad++; $display("FAIL oor_grant got ready=%b strobe=%b exp ready=1 strobe=0", if_req_ready, rom_rx_valid); end
    tick();
    drive(1'b1, 32'h0000_FFFC, 1'b0, '0);
    #1;
    total++; if ({if_resp_valid, if_resp_err, if_resp_data} !== {2'b11, 32'd0}) begin bad++; $display("FAIL oor_resp got=%b/%b/%h exp=1/1/0", if_resp_valid, if_resp_err, if_resp_data); end
    total++; if ({rom_rx_valid, rom_rx_addr} !== {1'b1, 32'h0000_FFFC}) begin bad++; $display("FAIL last_word_strobe got=%b/%h exp=1/0000fffc", rom_rx_valid, rom_rx_addr); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    #1;
    total++; if ({if_resp_valid, if_resp_err, if_resp_data} !== {2'b10, memf(30'h3FFF)}) begin bad++; $display("FAIL last_word_resp got=%b/%b/%h exp=1/0/%h", if_resp_valid, if_resp_err, if_resp_data, memf(30'h3FFF)); end
    tick();
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(1'b1, 32'(i * 4), 1'b0, '0);
      else drive(1'b0, '0, 1'b0, '0);
      #1;
      if (i > 0) begin
        total++; if ({if_resp_valid, if_resp_err, if_resp_data} !== {2'b10, memf(30'(i - 1))}) begin bad++; $display("FAIL b2b_resp[%0d] got=%b/%b/%h exp=1/0/%h", i - 1, if_resp_valid, if_resp_err, if_resp_data, memf(30'(i - 1))); end
      end
      tick();
    end
    total++; if (if_resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", if_resp_valid); end
  endtask

  task automatic test_reset_busy();
    reset_dut();
    drive(1'b1, 32'h4, 1'b0, '0);
    #1;
    total++; if (if_req_ready !== 1'b1) begin bad++; $display("FAIL rstbusy_accept got=%b exp=1", if_req_ready); end
    tick();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    #1;
    total++; if (if_resp_valid !== 1'b0) begin bad++; $display("FAIL rstbusy_drop got=%b exp=0", if_resp_valid); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data} !== 66'd0) begin bad++; $display("FAIL rstbusy_quiet[%0d] got v=%b%b d=%h/%h exp all 0", i, if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data); end
      tick();
    end
    drive(1'b1, 32'h20, 1'b1, 32'h40);
    #1;
    total++; if ({if_req_ready, ls_req_ready} !== (RR ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rstbusy_ptr got if=%b ls=%b exp rr=%b", if_req_ready, ls_req_ready, RR); end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    tick();
  endtask

  // Random traffic; a port that loses holds its request until granted.
  task automatic test_random();
    logic        iv, lv, hold_if, hold_ls, pref_ls, g_if, g_ls, g_err;
    logic [31:0] ia, la, g_addr;
    logic        pend_v, pend_ls, pend_err;
    logic [31:0] pend_addr, exp_d;
    hold_if = 1'b0; hold_ls = 1'b0; pref_ls = 1'b0;
    pend_v = 1'b0; pend_ls = 1'b0; pend_err = 1'b0; pend_addr = '0;
    iv = 1'b0; lv = 1'b0; ia = '0; la = '0;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      if (!hold_if) begin iv = 1'($urandom_range(0, 1)); ia = gen_addr(); end
      if (!hold_ls) begin lv = 1'($urandom_range(0, 1)); la = gen_addr(); end
      drive(iv, ia, lv, la);
      #1;
      g_ls   = lv && (!iv || !RR || pref_ls);
      g_if   = iv && !g_ls;
      g_addr = g_ls ? la : ia;
      g_err  = (g_if || g_ls) && model_err(g_addr);
      total++; if ({if_req_ready, ls_req_ready} !== {g_if, g_ls}) begin bad++; $display("FAIL rand_grant[%0d] got if=%b ls=%b exp if=%b ls=%b", c, if_req_ready, ls_req_ready, g_if, g_ls); end
      total++; if (rom_rx_valid !== ((g_if || g_ls) && !g_err) || (rom_rx_valid === 1'b1 && rom_rx_addr !== g_addr)) begin bad++; $display("FAIL rand_strobe[%0d] got=%b/%h exp addr=%h", c, rom_rx_valid, rom_rx_addr, g_addr); end
      exp_d = (pend_v && !pend_err) ? memf(pend_addr[31:2]) : 32'd0;
      total++; if ({if_resp_valid, if_resp_err, if_resp_data} !== ((pend_v && !pend_ls) ? {1'b1, pend_err, exp_d} : 34'd0)) begin bad++; $display("FAIL rand_if_resp[%0d] got=%b/%b/%h exp pend=%b port_ls=%b err=%b d=%h", c, if_resp_valid, if_resp_err, if_resp_data, pend_v, pend_ls, pend_err, exp_d); end
      total++; if ({ls_resp_valid, ls_resp_err, ls_resp_data} !== ((pend_v && pend_ls) ? {1'b1, pend_err, exp_d} : 34'd0)) begin bad++; $display("FAIL rand_ls_resp[%0d] got=%b/%b/%h exp pend=%b port_ls=%b err=%b d=%h", c, ls_resp_valid, ls_resp_err, ls_resp_data, pend_v, pend_ls, pend_err, exp_d); end
      if (g_if || g_ls) pref_ls = g_if;
      hold_if   = iv && !g_if;
      hold_ls   = lv && !g_ls;
      pend_v    = g_if || g_ls;
      pend_ls   = g_ls;
      pend_err  = g_err;
      pend_addr = g_addr;
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_contention();
    test_misaligned_ls();
    test_out_of_range();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
